// File: rtl/mem_io_bus_pkg.sv
// rtl/mem_io_bus_pkg.sv - shared types, constants and helpers for the CPU memory/IO router
package mem_io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM_RD,
        IO_WAIT,
        RESP
    } bus_state_e;

    localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

    // Lowest byte address of the IO window: every bit above the channel field set.
    function automatic logic [31:0] io_base(input int addr_w, input int io_addr_w, input int ch_w);
        logic [31:0] top_mask;
        logic [31:0] low_mask;
        top_mask = (32'd1 << addr_w) - 32'd1;
        low_mask = (32'd1 << (io_addr_w + ch_w)) - 32'd1;
        return top_mask & ~low_mask;
    endfunction

    function automatic logic [1:0] lane_enable(input logic byte_acc, input logic a0);
        if (!byte_acc) begin
            return 2'b11;
        end
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_io_decode.sv
// rtl/mem_io_decode.sv - combinational region, channel and byte-lane decode of a CPU byte address
module mem_io_decode
    import mem_io_bus_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int N_IO      = 4,
    parameter int IO_ADDR_W = 8,
    parameter int CH_W      = $clog2(N_IO)
) (
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic                 byte_i,
    output logic                 is_io_o,
    output logic [CH_W-1:0]      ch_o,
    output logic [IO_ADDR_W-1:0] io_addr_o,
    output logic [1:0]           be_o
);

    localparam logic [31:0]       IO_BASE = io_base(ADDR_W, IO_ADDR_W, CH_W);
    localparam logic [ADDR_W-1:0] IO_MASK = IO_BASE[ADDR_W-1:0];

    assign is_io_o   = (addr_i & IO_MASK) == IO_MASK;
    assign ch_o      = addr_i[IO_ADDR_W+CH_W-1:IO_ADDR_W];
    assign io_addr_o = addr_i[IO_ADDR_W-1:0];
    assign be_o      = lane_enable(byte_i, addr_i[0]);

endmodule

// File: rtl/mem_io_bus.sv
// rtl/mem_io_bus.sv - CPU router to RAM/BIOS and N IO channels with req/ack and bus-error timeout
// Optional access counters are built when MEM_IO_BUS_STATS_EN is defined.
module mem_io_bus
    import mem_io_bus_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16,
    parameter int N_IO      = 4,
    parameter int IO_ADDR_W = 8,
    parameter int RAM_LAT   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_cpu_req,
    input  logic                   i_cpu_we,
    input  logic                   i_cpu_be,
    input  logic [ADDR_W-1:0]      i_cpu_addr,
    input  logic [DATA_W-1:0]      i_cpu_wdata,
    output logic [DATA_W-1:0]      o_cpu_rdata,
    output logic                   o_cpu_ack,
    output logic                   o_cpu_err,
    output logic [ADDR_W-2:0]      o_ram_addr,
    output logic [DATA_W-1:0]      o_ram_wdata,
    output logic [1:0]             o_ram_be,
    output logic                   o_ram_we,
    input  logic [DATA_W-1:0]      i_ram_rdata,
    input  logic                   i_bios_ena,
    input  logic [DATA_W-1:0]      i_bios_rdata,
    output logic [N_IO-1:0]        o_io_sel,
    output logic [IO_ADDR_W-1:0]   o_io_addr,
    output logic [DATA_W-1:0]      o_io_wdata,
    output logic                   o_io_we,
    output logic                   o_io_re,
    input  logic [N_IO*DATA_W-1:0] i_io_rdata,
    input  logic [N_IO-1:0]        i_io_ready
`ifdef MEM_IO_BUS_STATS_EN
    ,
    output logic [31:0]            o_stat_ram_cnt,
    output logic [31:0]            o_stat_io_cnt,
    output logic [15:0]            o_stat_err_cnt
`endif
);

    localparam int                CH_W       = $clog2(N_IO);
    localparam int                HALF_W     = DATA_W / 2;
    localparam logic [ADDR_W-2:0] BIOS_WORDS = (ADDR_W-1)'(4096);

    bus_state_e           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 accept;

    logic [ADDR_W-1:0]    addr_q;
    logic                 we_q, byte_q, is_io_q;
    logic [CH_W-1:0]      ch_q;
    logic [IO_ADDR_W-1:0] io_addr_q;
    logic [1:0]           be_q;
    logic [DATA_W-1:0]    wdata_q;

    logic                 dec_is_io;
    logic [CH_W-1:0]      dec_ch;
    logic [IO_ADDR_W-1:0] dec_io_addr;
    logic [1:0]           dec_be;
    logic                 bios_hit;

    mem_io_decode #(
        .ADDR_W   (ADDR_W),
        .N_IO     (N_IO),
        .IO_ADDR_W(IO_ADDR_W),
        .CH_W     (CH_W)
    ) u_decode (
        .addr_i   (i_cpu_addr),
        .byte_i   (i_cpu_be),
        .is_io_o  (dec_is_io),
        .ch_o     (dec_ch),
        .io_addr_o(dec_io_addr),
        .be_o     (dec_be)
    );

    // Byte reads come back zero-extended in the low lane.
    function automatic logic [DATA_W-1:0] lane_data(input logic byte_acc, input logic a0,
                                                    input logic [DATA_W-1:0] d);
        if (!byte_acc) begin
            return d;
        end
        return a0 ? {{HALF_W{1'b0}}, d[DATA_W-1:HALF_W]} : {{HALF_W{1'b0}}, d[HALF_W-1:0]};
    endfunction

    assign bios_hit = i_bios_ena && (addr_q[ADDR_W-1:1] < BIOS_WORDS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        accept    = 1'b0;
        o_cpu_ack = 1'b0;
        o_cpu_err = 1'b0;
        o_ram_we  = 1'b0;
        o_io_we   = 1'b0;
        o_io_re   = 1'b0;
        o_io_sel  = '0;
        case (state_q)
            IDLE: begin
                if (i_cpu_req) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = dec_is_io ? IO_WAIT : RAM_RD;
                end
            end
            // Writes spend a single cycle here to strobe RAM; reads wait out the RAM latency.
            RAM_RD: begin
                o_ram_we = we_q;
                if (we_q) begin
                    state_d = RESP;
                end else if (cnt_q == 16'(RAM_LAT)) begin
                    rdata_d = lane_data(byte_q, addr_q[0], bios_hit ? i_bios_rdata : i_ram_rdata);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            IO_WAIT: begin
                o_io_sel[ch_q] = 1'b1;
                if (cnt_q == '0) begin
                    o_io_we = we_q;
                    o_io_re = !we_q;
                end
                if (i_io_ready[ch_q]) begin
                    if (!we_q) begin
                        rdata_d = lane_data(byte_q, addr_q[0], i_io_rdata[ch_q*DATA_W +: DATA_W]);
                    end
                    state_d = RESP;
                end else if (cnt_q == 16'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    rdata_d = BUS_ERR_DATA;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                o_cpu_ack = 1'b1;
                o_cpu_err = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            is_io_q   <= 1'b0;
            ch_q      <= '0;
            io_addr_q <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q    <= i_cpu_addr;
                we_q      <= i_cpu_we;
                byte_q    <= i_cpu_be;
                is_io_q   <= dec_is_io;
                ch_q      <= dec_ch;
                io_addr_q <= dec_io_addr;
                be_q      <= dec_be;
                wdata_q   <= i_cpu_be ? {2{i_cpu_wdata[HALF_W-1:0]}} : i_cpu_wdata;
            end
        end
    end

    assign o_cpu_rdata = rdata_q;
    assign o_ram_addr  = addr_q[ADDR_W-1:1];
    assign o_ram_wdata = wdata_q;
    assign o_ram_be    = be_q;
    assign o_io_addr   = io_addr_q;
    assign o_io_wdata  = wdata_q;

`ifdef MEM_IO_BUS_STATS_EN
    logic [31:0] stat_ram_q, stat_io_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ram_q <= '0;
            stat_io_q  <= '0;
            stat_err_q <= '0;
        end else if (state_q == RESP) begin
            if (is_io_q) begin
                if (!(&stat_io_q)) stat_io_q <= stat_io_q + 32'd1;
            end else begin
                if (!(&stat_ram_q)) stat_ram_q <= stat_ram_q + 32'd1;
            end
            if (err_q && !(&stat_err_q)) stat_err_q <= stat_err_q + 16'd1;
        end
    end

    assign o_stat_ram_cnt = stat_ram_q;
    assign o_stat_io_cnt  = stat_io_q;
    assign o_stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_mem_io_bus.sv
// tb/tb_mem_io_bus.sv - self-checking bench for mem_io_bus (vector table, random accesses, corner sequences)
`timescale 1ns/1ps
module tb_mem_io_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_cpu_req, i_cpu_we, i_cpu_be;
    logic [18:0] i_cpu_addr;
    logic [15:0] i_cpu_wdata, o_cpu_rdata;
    logic        o_cpu_ack, o_cpu_err;
    logic [17:0] o_ram_addr;
    logic [15:0] o_ram_wdata, i_ram_rdata, i_bios_rdata, o_io_wdata;
    logic [1:0]  o_ram_be;
    logic        o_ram_we, i_bios_ena, o_io_we, o_io_re;
    logic [3:0]  o_io_sel, i_io_ready;
    logic [7:0]  o_io_addr;
    logic [63:0] i_io_rdata;
`ifdef MEM_IO_BUS_STATS_EN
    logic [31:0] o_stat_ram_cnt, o_stat_io_cnt;
    logic [15:0] o_stat_err_cnt;
`endif

    always #5 clk = ~clk;

    mem_io_bus dut (
        .clk(clk), .reset(reset),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_be(i_cpu_be),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
        .o_cpu_rdata(o_cpu_rdata), .o_cpu_ack(o_cpu_ack), .o_cpu_err(o_cpu_err),
        .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .o_ram_be(o_ram_be), .o_ram_we(o_ram_we),
        .i_ram_rdata(i_ram_rdata), .i_bios_ena(i_bios_ena), .i_bios_rdata(i_bios_rdata),
        .o_io_sel(o_io_sel), .o_io_addr(o_io_addr), .o_io_wdata(o_io_wdata),
        .o_io_we(o_io_we), .o_io_re(o_io_re), .i_io_rdata(i_io_rdata), .i_io_ready(i_io_ready)
`ifdef MEM_IO_BUS_STATS_EN
        , .o_stat_ram_cnt(o_stat_ram_cnt), .o_stat_io_cnt(o_stat_io_cnt), .o_stat_err_cnt(o_stat_err_cnt)
`endif
    );

    // External devices: registered RAM and BIOS ROM, combinational IO register files.
    logic [15:0] ram_dev [0:1023];
    bit          mem_init = 1'b0;
    int          ready_delay = -1;
    int          io_cyc = 0;
    logic [3:0]  noise = 4'h0;

    function automatic logic [15:0] bios_fn(input logic [17:0] w);
        return w[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_val(input int ch, input logic [7:0] ra);
        return 16'hC000 | 16'(ch << 8) | {8'h00, ra};
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) ram_dev[i] <= 16'h0000;
            mem_init <= 1'b1;
        end else if (o_ram_we) begin
            if (o_ram_be[0]) ram_dev[o_ram_addr[9:0]][7:0]  <= o_ram_wdata[7:0];
            if (o_ram_be[1]) ram_dev[o_ram_addr[9:0]][15:8] <= o_ram_wdata[15:8];
        end
        i_ram_rdata  <= ram_dev[o_ram_addr[9:0]];
        i_bios_rdata <= bios_fn(o_ram_addr);
        io_cyc       <= (o_io_sel != 4'h0) ? io_cyc + 1 : 0;
    end

    always_comb begin
        i_io_rdata = '0;
        for (int k = 0; k < 4; k++) i_io_rdata[k*16 +: 16] = dev_val(k, o_io_addr);
    end

    assign i_io_ready = (o_io_sel != 4'h0 && io_cyc == ready_delay) ? o_io_sel : (noise & ~o_io_sel);

    // Reference model: byte-addressed memory image plus the address-map rules.
    logic [7:0] ref_mem [0:2047];

    function automatic logic [15:0] pick_lane(input logic bt, input logic a0, input logic [15:0] w);
        if (!bt) return w;
        return a0 ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    endfunction

    function automatic logic [15:0] model_read(input logic bt, input logic [18:0] a, input logic bios);
        logic [10:0] b;
        b = a[10:0];
        if (a >= 19'h7FC00) return pick_lane(bt, a[0], dev_val(int'(a[9:8]), a[7:0]));
        if (bios && a[18:1] < 18'd4096) return pick_lane(bt, a[0], bios_fn(a[18:1]));
        if (bt) return {8'h00, ref_mem[b]};
        return {ref_mem[b | 11'd1], ref_mem[b & ~11'd1]};
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_access(input string nm, input logic we, input logic bt, input logic [18:0] a,
                             input logic [15:0] wd, input logic bios, input int d,
                             input logic [15:0] exp_rd, input logic exp_err, input int exp_lat);
        int          lat;
        int          n_rw, n_ire, n_iwe;
        logic        is_io;
        logic [1:0]  exp_be;
        logic [15:0] exp_wd, got_rd;
        logic        got_err;
        lat = -1; n_rw = 0; n_ire = 0; n_iwe = 0; got_rd = 16'h0; got_err = 1'b0;
        is_io  = (a >= 19'h7FC00);
        exp_be = bt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
        exp_wd = bt ? {wd[7:0], wd[7:0]} : wd;
        i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_be = bt; i_cpu_addr = a; i_cpu_wdata = wd;
        i_bios_ena = bios; ready_delay = d; noise = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (o_ram_we) begin
                n_rw++;
                chk({nm, " ram_be"}, 32'(o_ram_be), 32'(exp_be));
                chk({nm, " ram_addr"}, 32'(o_ram_addr), 32'(a[18:1]));
                chk({nm, " ram_wdata"}, 32'(o_ram_wdata), 32'(exp_wd));
            end
            if (o_io_re || o_io_we) begin
                n_ire += int'(o_io_re);
                n_iwe += int'(o_io_we);
                chk({nm, " io_sel"}, 32'(o_io_sel), 32'(4'b0001 << a[9:8]));
                chk({nm, " io_addr"}, 32'(o_io_addr), 32'(a[7:0]));
                if (we) chk({nm, " io_wdata"}, 32'(o_io_wdata), 32'(exp_wd));
            end
            if (o_cpu_ack) begin
                lat = c; got_rd = o_cpu_rdata; got_err = o_cpu_err;
                break;
            end
            if (c >= 1) begin
                i_cpu_addr = 19'($urandom); i_cpu_wdata = 16'($urandom);
                i_cpu_we = 1'($urandom); i_cpu_be = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        i_cpu_req = 1'b0; ready_delay = -1; noise = 4'h0;
        chk({nm, " ack_cycle"}, 32'(lat), 32'(exp_lat));
        chk({nm, " err"}, 32'(got_err), 32'(exp_err));
        if (!we || exp_err) chk({nm, " rdata"}, 32'(got_rd), 32'(exp_rd));
        chk({nm, " ram_we_pulses"}, 32'(n_rw), 32'(!is_io && we));
        chk({nm, " io_re_pulses"}, 32'(n_ire), 32'(is_io && !we));
        chk({nm, " io_we_pulses"}, 32'(n_iwe), 32'(is_io && we));
        if (!is_io && we) begin
            if (bt) ref_mem[a[10:0]] = wd[7:0];
            else begin
                ref_mem[a[10:0] & ~11'd1] = wd[7:0];
                ref_mem[a[10:0] | 11'd1]  = wd[15:8];
            end
        end
    endtask

    typedef struct {
        string       nm;
        logic        we, bt;
        logic [18:0] a;
        logic [15:0] wd;
        logic        bios;
        int          d;
        logic [15:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic we, input logic bt, input logic [18:0] a,
                       input logic [15:0] wd, input logic bios, input int d,
                       input logic [15:0] rd, input logic err, input int lat);
        vec_t v;
        v.nm = nm; v.we = we; v.bt = bt; v.a = a; v.wd = wd; v.bios = bios;
        v.d = d; v.rd = rd; v.err = err; v.lat = lat;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ack_mask;
        int          n_ack;
        logic        we, bt, bios, io;
        logic [18:0] a;
        logic [15:0] wd;
        int          d;

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        reset = 1'b1; i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_cpu_be = 1'b0;
        i_cpu_addr = '0; i_cpu_wdata = '0; i_bios_ena = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset ack", 32'(o_cpu_ack), 32'd0);
        chk("reset err", 32'(o_cpu_err), 32'd0);
        chk("reset strobes", {29'd0, o_ram_we, o_io_we, o_io_re}, 32'd0);
        chk("reset sel", 32'(o_io_sel), 32'd0);
        chk("reset rdata", 32'(o_cpu_rdata), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        add("wr_word",    1, 0, 19'h00100, 16'h1234, 0, -1, 16'h0000, 0, 2);
        add("rd_word",    0, 0, 19'h00100, 16'h0000, 0, -1, 16'h1234, 0, 3);
        add("wr_byte_hi", 1, 1, 19'h00101, 16'h77AB, 0, -1, 16'h0000, 0, 2);
        add("rd_byte_hi", 0, 1, 19'h00101, 16'h0000, 0, -1, 16'h00AB, 0, 3);
        add("rd_word_mix",0, 0, 19'h00100, 16'h0000, 0, -1, 16'hAB34, 0, 3);
        add("rd_byte_lo", 0, 1, 19'h00100, 16'h0000, 0, -1, 16'h0034, 0, 3);
        add("io_rd_ch2",  0, 0, 19'h7FE05, 16'h0000, 0,  3, 16'hC205, 0, 5);
        add("io_wr_ch0",  1, 0, 19'h7FC10, 16'hBEEF, 0,  0, 16'h0000, 0, 2);
        add("io_rd_byte", 0, 1, 19'h7FF81, 16'h0000, 0,  1, 16'h00C3, 0, 3);
        add("bios_rd",    0, 0, 19'h00010, 16'h0000, 1, -1, 16'h5A52, 0, 3);
        add("bios_wr",    1, 0, 19'h00010, 16'h5555, 1, -1, 16'h0000, 0, 2);
        add("ram_rd_nob", 0, 0, 19'h00010, 16'h0000, 0, -1, 16'h5555, 0, 3);
        add("io_timeout", 0, 0, 19'h7FD00, 16'h0000, 0, -1, 16'hDEAD, 1, 257);
        foreach (tbl[i])
            do_access(tbl[i].nm, tbl[i].we, tbl[i].bt, tbl[i].a, tbl[i].wd, tbl[i].bios,
                      tbl[i].d, tbl[i].rd, tbl[i].err, tbl[i].lat);

        // Request held through ack: the second access starts only in the following IDLE cycle.
        ack_mask = '0;
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_be = 1'b0; i_cpu_addr = 19'h00200;
        i_cpu_wdata = 16'h7777; i_bios_ena = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ack_mask[c] = o_cpu_ack;
        end
        @(posedge clk); #1;
        i_cpu_req = 1'b0;
        chk("held_req ack_pattern", 32'(ack_mask), 32'b100100);
        ref_mem[11'h200] = 8'h77; ref_mem[11'h201] = 8'h77;
        do_access("held_req readback", 0, 0, 19'h00200, 16'h0, 0, -1, 16'h7777, 0, 3);

        // Reset while an IO access waits: abandoned with no ack, then a clean access.
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_be = 1'b0; i_cpu_addr = 19'h7FD40;
        ready_delay = -1; noise = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1; i_cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset sel", 32'(o_io_sel), 32'd0);
        chk("midreset ack", 32'(o_cpu_ack), 32'd0);
        chk("midreset rdata", 32'(o_cpu_rdata), 32'd0);
        n_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_ack += int'(o_cpu_ack);
        end
        chk("midreset no_late_ack", 32'(n_ack), 32'd0);
        @(posedge clk); #1;
        do_access("post_reset io_rd", 0, 0, 19'h7FD40, 16'h0, 0, 2, 16'hC140, 0, 4);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 150; n++) begin
            io   = ($urandom_range(0, 3) == 0);
            we   = 1'($urandom);
            bt   = 1'($urandom);
            bios = ($urandom_range(0, 3) == 0);
            wd   = 16'($urandom);
            d    = $urandom_range(0, 5);
            if (io) a = 19'h7FC00 | 19'($urandom_range(0, 1023));
            else begin
                a = 19'($urandom_range(0, 2047));
                if ($urandom_range(0, 2) == 0) a = a | 19'h40000;
            end
            do_access($sformatf("rand%0d", n), we, bt, a, wd, bios, d, model_read(bt, a, bios), 1'b0,
                      io ? 2 + d : (we ? 2 : 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
